// File: rtl/popcount_stream_if.sv
// Write port of the popcount stream: one word plus its counting mode,
// with a valid/ready handshake.
interface popcount_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] WRITE_DATA;
  logic                  WRITE_MODE;
  logic                  WRITE_VALID;
  logic                  WRITE_READY;

  modport master (
    output WRITE_DATA,
    output WRITE_MODE,
    output WRITE_VALID,
    input  WRITE_READY
  );

  modport slave (
    input  WRITE_DATA,
    input  WRITE_MODE,
    input  WRITE_VALID,
    output WRITE_READY
  );
endinterface

// File: rtl/popcount_stream.sv
// Streaming population counter: words enter a small FIFO, are consumed
// BITS_PER_CYCLE bits per cycle, and accumulate into a saturating COUNT.
module popcount_stream #(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 8,
  parameter int COUNT_WIDTH    = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  popcount_stream_if.slave       wr,
  output logic [COUNT_WIDTH-1:0] COUNT,
  output logic [COUNT_WIDTH-1:0] WORDS,
  output logic                   OVERFLOW,
  input  logic                   COUNT_RST,
  output logic                   COUNT_BUSY
);
  localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PCW   = $clog2(BITS_PER_CYCLE + 1);

  typedef enum logic {ST_IDLE, ST_COUNT} state_t;

  state_t state_reg, state_next;

  // FIFO storage holds {mode, data}; pointers carry one wrap bit
  logic [DATA_WIDTH:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_reg;
  logic [AW:0]         rd_ptr_reg;
  logic                fifo_empty;
  logic                fifo_full;

  logic [DATA_WIDTH-1:0]  shift_reg;
  logic                   mode_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [COUNT_WIDTH-1:0] words_reg;
  logic                   overflow_reg;

  logic                      push;
  logic                      pop;
  logic                      last_chunk;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [PCW-1:0]            chunk_ones;
  logic [COUNT_WIDTH:0]      sum;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Readiness depends only on the registered full flag, so a pop in a full
  // cycle never opens a push slot in that same cycle.
  assign wr.WRITE_READY = !fifo_full && !ARESET;
  assign push           = wr.WRITE_VALID && wr.WRITE_READY;

  assign last_chunk = (state_reg == ST_COUNT) && (idx_reg == IDX_W'(N - 1));
  // Pop when idle, or on the final chunk so the next word follows with no bubble
  assign pop = !fifo_empty && ((state_reg == ST_IDLE) || last_chunk);

  assign chunk = shift_reg[BITS_PER_CYCLE-1:0] ^ {BITS_PER_CYCLE{mode_reg}};
  assign sum   = {1'b0, count_reg} + (COUNT_WIDTH + 1)'(chunk_ones);

  // Population count of the current chunk
  always_comb begin
    chunk_ones = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      chunk_ones = chunk_ones + PCW'(chunk[i]);
    end
  end

  // Next-state logic: leave IDLE as soon as a word is queued, return only
  // when the last chunk finishes with nothing waiting
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (!fifo_empty) state_next = ST_COUNT;
      ST_COUNT: if (last_chunk && fifo_empty) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // FIFO storage write (no reset needed; validity tracked by pointers)
  always_ff @(posedge ACLK) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= {wr.WRITE_MODE, wr.WRITE_DATA};
  end

  // FIFO pointers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
    end
  end

  // Shift register and chunk index: load on pop, otherwise advance one chunk
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      shift_reg <= '0;
      mode_reg  <= 1'b0;
      idx_reg   <= '0;
    end else if (pop) begin
      shift_reg <= fifo_mem[rd_ptr_reg[AW-1:0]][DATA_WIDTH-1:0];
      mode_reg  <= fifo_mem[rd_ptr_reg[AW-1:0]][DATA_WIDTH];
      idx_reg   <= '0;
    end else if (state_reg == ST_COUNT) begin
      shift_reg <= shift_reg >> BITS_PER_CYCLE;
      idx_reg   <= idx_reg + IDX_W'(1);
    end
  end

  // Accumulators: a software clear overrides this cycle's chunk and word update
  always_ff @(posedge ACLK) begin
    if (ARESET || COUNT_RST) begin
      count_reg    <= '0;
      words_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (state_reg == ST_COUNT) begin
      if (sum[COUNT_WIDTH]) begin
        count_reg    <= '1;
        overflow_reg <= 1'b1;
      end else begin
        count_reg <= sum[COUNT_WIDTH-1:0];
      end
      if (last_chunk) words_reg <= words_reg + COUNT_WIDTH'(1);
    end
  end

  assign COUNT      = count_reg;
  assign WORDS      = words_reg;
  assign OVERFLOW   = overflow_reg;
  assign COUNT_BUSY = (state_reg == ST_COUNT) || !fifo_empty;
endmodule
